// File: rtl/poly_voice_engine.sv
// poly_voice_engine: time-multiplexed polyphonic oscillator and mixer.
// A single shared waveform/volume datapath visits one voice per cycle.
// Each frame sums every voice into a wide accumulator, then saturates the
// sum into one signed output sample.
module poly_voice_engine #(
  parameter int N_VOICES = 8,
  parameter int PHASE_W  = 24,
  parameter int VOL_W    = 8,
  parameter int OUT_W    = 16,
  parameter int VI_W     = $clog2(N_VOICES)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_tick,
  input  logic                    cfg_we,
  input  logic [VI_W-1:0]         cfg_voice,
  input  logic [PHASE_W-1:0]      cfg_inc,
  input  logic [VOL_W-1:0]        cfg_vol,
  input  logic [1:0]              cfg_wave,
  input  logic                    cfg_gate,
  input  logic                    ovr_clr,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int ACC_W  = OUT_W + VI_W + 1;
  localparam int PROD_W = OUT_W + VOL_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_SAT  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_SAW    = 2'd2;
  localparam logic [1:0] WAVE_TRI    = 2'd3;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(VI_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(VI_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  // Per-voice state and configuration tables.
  logic [PHASE_W-1:0] phase_q [N_VOICES];
  logic [PHASE_W-1:0] inc_q   [N_VOICES];
  logic [VOL_W-1:0]   vol_q   [N_VOICES];
  logic [1:0]         wave_q  [N_VOICES];
  logic [N_VOICES-1:0] gate_q;

  logic [1:0]              state_q;
  logic [VI_W-1:0]         v_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [OUT_W-1:0] stage_q;

  logic [PHASE_W-1:0]       p;
  logic [OUT_W-1:0]         top;
  logic [OUT_W-1:0]         tri_t;
  logic signed [OUT_W-1:0]  wave_val;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] scaled;
  logic signed [ACC_W-1:0]  scaled_acc;
  logic signed [OUT_W-1:0]  sat_val;
  logic                     last_voice;

  assign busy       = (state_q != S_IDLE);
  assign last_voice = (v_q == VI_W'(N_VOICES - 1));

  // Shared datapath: waveform of the current voice from its pre-update phase, scaled by volume.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wave_val = '0;
    p        = phase_q[v_q];
    top      = p[PHASE_W-1 -: OUT_W];
    tri_t    = p[PHASE_W-2 -: OUT_W];
    if (p[PHASE_W-1]) tri_t = ~tri_t;
    if (gate_q[v_q]) begin
      case (wave_q[v_q])
        WAVE_SQUARE: wave_val = p[PHASE_W-1] ? {1'b1, {(OUT_W - 1){1'b0}}}
                                             : {1'b0, {(OUT_W - 1){1'b1}}};
        WAVE_SAW:    wave_val = {~top[OUT_W-1], top[OUT_W-2:0]};
        WAVE_TRI:    wave_val = {~tri_t[OUT_W-1], tri_t[OUT_W-2:0]};
        default:     wave_val = '0;
      endcase
    end
    prod       = PROD_W'(wave_val) * PROD_W'($signed({1'b0, vol_q[v_q]}));
    scaled     = prod >>> VOL_W;
    scaled_acc = ACC_W'(scaled);
  end

  // Clamp the frame sum into the signed output range.
  always_comb begin
    sat_val = acc_q[OUT_W-1:0];
    if (acc_q > SAT_MAX)      sat_val = SAT_MAX[OUT_W-1:0];
    else if (acc_q < SAT_MIN) sat_val = SAT_MIN[OUT_W-1:0];
  end

  // Configuration write port; out-of-range voice indices are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the voice tables are small flop arrays, so they are reset explicitly; a silent reset state depends on it.
      for (int i = 0; i < N_VOICES; i++) begin
        inc_q[i]  <= '0;
        vol_q[i]  <= '0;
        wave_q[i] <= '0;
      end
      gate_q <= '0;
    end else if (cfg_we && (32'(cfg_voice) < N_VOICES)) begin
      inc_q[cfg_voice]  <= cfg_inc;
      vol_q[cfg_voice]  <= cfg_vol;
      wave_q[cfg_voice] <= cfg_wave;
      gate_q[cfg_voice] <= cfg_gate;
    end
  end

  // Phase accumulators: advance the visited voice, or park it at 0 while gated off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_VOICES; i++) phase_q[i] <= '0;
    end else if (state_q == S_RUN) begin
      phase_q[v_q] <= gate_q[v_q] ? (p + inc_q[v_q]) : '0;
    end
  end

  // Frame sequencer: IDLE -> RUN (one voice per cycle) -> SAT -> OUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      v_q          <= '0;
      acc_q        <= '0;
      stage_q      <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      sample_valid <= 1'b0;
      case (state_q)
        S_IDLE: if (sample_tick) begin
          acc_q   <= '0;
          v_q     <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          acc_q <= acc_q + scaled_acc;
          if (last_voice) state_q <= S_SAT;
          else            v_q     <= v_q + 1'b1;
        end
        S_SAT: begin
          stage_q <= sat_val;
          state_q <= S_OUT;
        end
        default: begin
          sample_out   <= stage_q;
          sample_valid <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun: a tick while busy sets it; setting takes priority over clearing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  overrun <= 1'b0;
    else if (sample_tick && busy)  overrun <= 1'b1;
    else if (ovr_clr)              overrun <= 1'b0;
  end

endmodule

// File: tb/tb_poly_voice_engine.sv
// Directed bench for poly_voice_engine: a table of single-voice waveform
// vectors, then hand sequences for timing, clamping, wrap, overrun and reset.
module tb_poly_voice_engine;

  localparam logic [1:0] W_OFF = 2'd0, W_SQ = 2'd1, W_SAW = 2'd2, W_TRI = 2'd3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              sample_tick = 1'b0;
  logic              cfg_we = 1'b0;
  logic [2:0]        cfg_voice = '0;
  logic [23:0]       cfg_inc = '0;
  logic [7:0]        cfg_vol = '0;
  logic [1:0]        cfg_wave = '0;
  logic              cfg_gate = 1'b0;
  logic              ovr_clr = 1'b0;
  logic signed [15:0] sample_out;
  logic              sample_valid;
  logic              busy;
  logic              overrun;

  int n_vec = 0;
  int n_err = 0;

  poly_voice_engine dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_tick  (sample_tick),
    .cfg_we       (cfg_we),
    .cfg_voice    (cfg_voice),
    .cfg_inc      (cfg_inc),
    .cfg_vol      (cfg_vol),
    .cfg_wave     (cfg_wave),
    .cfg_gate     (cfg_gate),
    .ovr_clr      (ovr_clr),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wave;
    logic [7:0]  vol;
    logic [23:0] inc;
    logic        gate;
    int          exp1;
    int          exp2;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cfg(input int v, input logic [23:0] inc, input logic [7:0] vol,
                     input logic [1:0] wave, input logic gate);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_voice = 3'(v);
    cfg_inc   = inc;
    cfg_vol   = vol;
    cfg_wave  = wave;
    cfg_gate  = gate;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  // Pulse a tick and wait (bounded) for the resulting sample.
  task automatic run_frame(output int s);
    bit found;
    found = 1'b0;
    s = 0;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (sample_valid) begin
        found = 1'b1;
        s = int'(sample_out);
      end else begin
        @(negedge clk);
      end
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_timeout: got no sample_valid expected one within 40 cycles");
    end
  endtask

  // Silence every voice and run one frame so all phases return to 0.
  task automatic clear_voices();
    int s;
    for (int i = 0; i < 8; i++) cfg(i, 24'h0, 8'h0, W_OFF, 1'b0);
    run_frame(s);
  endtask

  initial begin
    int s;
    int cnt;
    bit ok;

    vecs[0] = '{W_SQ,  8'd255, 24'h000000, 1'b1,  32639,  32639};
    vecs[1] = '{W_SAW, 8'd255, 24'h010000, 1'b1, -32640, -32385};
    vecs[2] = '{W_TRI, 8'd255, 24'h400000, 1'b1, -32640,      0};
    vecs[3] = '{W_SQ,  8'd128, 24'h800000, 1'b1,  16383, -16384};
    vecs[4] = '{W_OFF, 8'd255, 24'h000001, 1'b1,      0,      0};
    vecs[5] = '{W_SAW, 8'd0,   24'h010000, 1'b1,      0,      0};
    vecs[6] = '{W_SQ,  8'd255, 24'h800000, 1'b0,      0,      0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_sample_out", int'(sample_out), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    reset_n = 1'b1;

    // Single-voice waveform table, two frames each
    for (int i = 0; i < 7; i++) begin
      clear_voices();
      cfg(0, vecs[i].inc, vecs[i].vol, vecs[i].wave, vecs[i].gate);
      run_frame(s);
      check($sformatf("vec%0d_frame1", i), s, vecs[i].exp1);
      run_frame(s);
      check($sformatf("vec%0d_frame2", i), s, vecs[i].exp2);
    end

    // Frame latency: valid 11 cycles after the tick cycle, busy in the 10 between
    clear_voices();
    cfg(0, 24'h0, 8'd255, W_SQ, 1'b1);
    @(negedge clk);
    sample_tick = 1'b1;
    ok = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      sample_tick = 1'b0;
      if (!busy || sample_valid) ok = 1'b0;
    end
    check("lat_busy_no_early_valid", int'(ok), 1);
    @(negedge clk);
    check("lat_valid_c11", int'(sample_valid), 1);
    check("lat_busy_c11", int'(busy), 0);
    check("lat_sample", int'(sample_out), 32639);
    @(negedge clk);
    check("lat_valid_one_cycle", int'(sample_valid), 0);

    // All eight voices in phase: clamp positive then negative
    clear_voices();
    for (int i = 0; i < 8; i++) cfg(i, 24'h800000, 8'd255, W_SQ, 1'b1);
    run_frame(s);
    check("clamp_pos", s, 32767);
    run_frame(s);
    check("clamp_neg", s, -32768);

    // Phase wrap through 2^24
    clear_voices();
    cfg(0, 24'hFFFFFF, 8'd255, W_SAW, 1'b1);
    run_frame(s);
    check("wrap_f1", s, -32640);
    run_frame(s);
    check("wrap_f2", s, 32639);
    cfg(0, 24'h000002, 8'd255, W_SAW, 1'b1);
    run_frame(s);
    check("wrap_f3_phase_fffffe", s, 32639);
    run_frame(s);
    check("wrap_f4_phase_0", s, -32640);

    // Overrun: tick 3 cycles into a frame
    clear_voices();
    cfg(0, 24'h0, 8'd255, W_SQ, 1'b1);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (2) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check("ovr_set", int'(overrun), 1);
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      if (sample_valid) cnt++;
      @(negedge clk);
    end
    check("ovr_single_valid", cnt, 1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_cleared", int'(overrun), 0);
    // Tick and clear together while busy: set wins
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    sample_tick = 1'b1;
    ovr_clr = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    ovr_clr = 1'b0;
    check("ovr_set_wins", int'(overrun), 1);
    repeat (15) @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;

    // Reset in the middle of RUN (voice 4)
    clear_voices();
    cfg(0, 24'h800000, 8'd255, W_SQ, 1'b1);
    run_frame(s);
    check("pre_reset_frame", s, 32639);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_sample_out", int'(sample_out), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_valid", int'(sample_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sample_valid) cnt++;
    end
    check("mid_rst_no_valid", cnt, 0);
    cfg(0, 24'h800000, 8'd255, W_SQ, 1'b1);
    run_frame(s);
    check("post_reset_frame", s, 32639);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/poly_voice_engine.md
Name: poly_voice_engine

Overview:
- Parametrised, time-multiplexed polyphonic oscillator and mixer; successor to the fixed 8-voice square/saw synthesizer.
- N_VOICES phase-accumulator voices share one waveform/volume datapath. Each voice has its own waveform, volume and gate, set through a register write port.
- Each sample_tick starts one mixing frame. The frame yields one saturated signed sample, which feeds the downstream low-pass filter bank and audio output.

Parameters:
- N_VOICES, 8, number of voices; must be ≥2.
- PHASE_W, 24, phase accumulator width; must be ≥ OUT_W+1.
- VOL_W, 8, unsigned per-voice volume width.
- OUT_W, 16, signed output sample width.
- VI_W, $clog2(N_VOICES), voice index width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle strobe; starts a frame.
- cfg_we  in  1  configuration write enable.
- cfg_voice  in  VI_W  voice index being written.
- cfg_inc  in  PHASE_W  phase increment per frame.
- cfg_vol  in  VOL_W  voice volume.
- cfg_wave  in  2  waveform select: 0 off, 1 square, 2 saw, 3 triangle.
- cfg_gate  in  1  voice enable.
- ovr_clr  in  1  clears the overrun flag.
- sample_out  out  OUT_W  signed mixed sample.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  frame in progress.
- overrun  out  1  sticky flag: a tick arrived while busy.

Behaviour:

Reset (reset_n low, applied asynchronously):
- sample_out=0, sample_valid=0, busy=0, overrun=0.
- All phases, increments, volumes, wave selects and gates cleared to 0.
- FSM goes to IDLE.
- Reset asserted mid-frame aborts the frame; no sample_valid is produced.

Config write:
- When cfg_we=1, the voice cfg_voice registers cfg_inc/vol/wave/gate on the clock edge.
- A cfg_voice value ≥ N_VOICES is ignored.
- If the FSM reads the same voice in the same cycle as the write, it uses the old values. The new values apply from the next frame.

FSM states: IDLE, RUN, SAT, OUT.
- IDLE: when sample_tick=1, clear the accumulator, set voice index v=0, go to RUN.
- RUN: one voice per cycle, v = 0..N_VOICES-1. After v=N_VOICES-1, go to SAT.
- SAT: saturate the accumulator into a staging register, go to OUT.
- OUT: update sample_out, assert sample_valid for this cycle, go to IDLE.
- busy=1 in RUN, SAT and OUT.

Timing:
- Tick sampled at edge T → RUN over cycles T+1..T+N_VOICES.
- sample_valid is high in cycle T+N_VOICES+3; N_VOICES+3 edges after the tick (11 for the default).
- A new tick is accepted in IDLE from the cycle after OUT.

Overrun:
- sample_tick=1 while busy=1 is ignored and sets overrun=1.
- ovr_clr=1 clears overrun. If a tick-while-busy and ovr_clr occur in the same cycle, set wins.

Per-voice processing in RUN (p = phase before update, top = p[PHASE_W-1 -: OUT_W]):
- square: +(2^(OUT_W-1)-1) if p[PHASE_W-1]=0, else -2^(OUT_W-1).
- saw: top with its MSB inverted, interpreted as signed.
- triangle: t = p[PHASE_W-2 -: OUT_W]; if p[PHASE_W-1]=1, t = ~t; then invert the MSB of t and interpret as signed.
- off, or gate=0: waveform value is 0.
- Scaled value = (wave × vol) >>> VOL_W, arithmetic shift (floor).
- Accumulator is signed, OUT_W+VI_W+1 bits wide; it cannot overflow.

Phase update (same cycle):
- gate=1: phase ← (p + inc) mod 2^PHASE_W; wraps silently.
- gate=0: phase ← 0, so the next note starts at phase 0.
- The waveform always uses p, the pre-increment value.

Saturation:
- Sum > 2^(OUT_W-1)-1 clamps to 2^(OUT_W-1)-1.
- Sum < -2^(OUT_W-1) clamps to -2^(OUT_W-1).
- No wrap.

Test Plan:
- Default params. Voice0: square, vol 255, gate 1, inc 0; all other voices gate 0. Tick → sample_valid exactly 11 cycles later with sample_out=32639; busy high in the 10 cycles before it.
- Voice0: saw, vol 255, gate 1, inc 0x010000. Frame 1 → -32640. Frame 2 (top=0x0100, signed -32512) → -32385.
- All 8 voices: square, vol 255, inc 0x800000, gate 1. Frame 1 → +32767 (sum 261112, clamped). Frame 2 (phase 0x800000) → -32768 (sum -261120, clamped).
- Voice0: inc 0xFFFFFF, gate 1. After 2 frames the phase wraps to 0xFFFFFE. Then inc 2: phase 0xFFFFFE wraps to 0x000000; no X values, no stall.
- Tick issued 3 cycles into a frame → overrun=1, only one sample_valid produced. Then ovr_clr pulse → overrun=0. Tick and ovr_clr in the same busy cycle → overrun stays 1.
- reset_n pulsed low during RUN (v=4) → all outputs 0 immediately, no sample_valid. After release, a new tick with the same config reproduces the first-frame value (phases restarted at 0).
